serial_subtractor: RTL

//   Bit-serial, LSB-first subtractor computing a - b over WIDTH cycles with one

---
 rtl/serial_subtractor.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial, LSB-first subtractor computing a - b over WIDTH clock edges.
// It uses one full-subtractor cell and a registered borrow. Operands are
// loaded on an accepted start. Each SHIFT edge then consumes one bit pair
// plus the borrow-in and shifts the difference bit into a result register
// from the MSB side. The visible diff/borrow_out outputs update only on the
// final SHIFT edge, so observers never see partial results.
//
// Parameters
//   WIDTH       operand / result width in bits (>= 1)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request, honoured only in IDLE or DONE
//   a, b        minuend / subtrahend, captured on the accepted start edge
//   busy        high while bits are being processed (SHIFT)
//   done        one-cycle pulse, diff/borrow_out valid
//   diff        a - b mod 2**WIDTH, held until the next completed operation
//   borrow_out  1 iff a < b (unsigned), held like diff
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // One extra bit so WIDTH-1 always fits without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;

    // Full-subtractor cell on the current LSBs and the registered borrow.
    logic             a0, b0, bin;
    logic             d_bit, bo_bit;
    logic [WIDTH-1:0] res_shift;
    logic             load;

    always_comb begin
        a0     = a_sr_q[0];
        b0     = b_sr_q[0];
        bin    = borrow_q;
        d_bit  = a0 ^ b0 ^ bin;
        bo_bit = (~a0 & (b0 ^ bin)) | (b0 & bin);

        // Result register shifts right; the new bit enters at the MSB so the
        // first (LSB) difference bit ends up at bit 0 after WIDTH shifts.
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = d_bit;
    end

    // A new operation can only be accepted when not in the middle of one.
    assign load = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        res_d        = res_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_d    = res_shift;
                borrow_d = bo_bit;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    // Publish the completed result on the same edge that
                    // processes the last bit.
                    diff_d       = res_shift;
                    borrow_out_d = bo_bit;
                    state_d      = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            res_q        <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            res_q        <= res_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    assign busy       = (state_q == ST_SHIFT);
    assign done       = (state_q == ST_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule
